// File: rtl/fpu_result_merge.sv
// Merges results from three FPU paths into one stream in dispatch order. An
// order queue records the class of each dispatch. Each path has a one-entry
// holding register that is drained into a single output register.

module fpu_rm_path #(
  parameter int W  = 37,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         res_valid_i,
  input  logic [W-1:0] res_data_i,
  input  logic         drain_i,
  output logic         res_ready_o,
  output logic         hold_vld_o,
  output logic [W-1:0] hold_data_o,
  output logic         drop_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic [W-1:0]  data_q;
  logic          capture, accept;

  assign capture = res_valid_i & ~vld_q;
  // A result is stray when nothing is outstanding and no same-cycle dispatch covers it.
  assign drop_o  = capture & (cnt_q == '0) & ~push_i;
  assign accept  = capture & ~drop_o;

  always_comb begin
    cnt_d = cnt_q + CW'(push_i) - CW'(accept);
    vld_d = vld_q;
    if (accept)       vld_d = 1'b1;
    else if (drain_i) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
      if (accept) data_q <= res_data_i;
    end
  end

  assign res_ready_o = ~vld_q;
  assign hold_vld_o  = vld_q;
  assign hold_data_o = data_q;
endmodule

module fpu_result_merge #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         issue_valid,
  input  logic [1:0]   issue_type,
  output logic         issue_ready,
  input  logic [2:0]   res_valid,
  input  logic [W-1:0] res_data0,
  input  logic [W-1:0] res_data1,
  input  logic [W-1:0] res_data2,
  output logic [2:0]   res_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_type,
  input  logic         out_ready,
  output logic         err
);
  localparam int AW = $clog2(DEPTH);
  localparam int NP = 3;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DEPTH-1:0][1:0]  q_mem_q;
  logic [AW:0]            wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic                   full, empty, push, load;
  logic [1:0]             head;
  logic [NP-1:0][W-1:0]   res_data, hold_data;
  logic [NP-1:0]          hold_vld, drop, drain, push_cls;
  logic [3:0]             head_vld_vec;
  logic [W-1:0]           head_data;
  logic                   out_valid_q, out_valid_d, err_q;
  logic [W-1:0]           out_data_q;
  logic [1:0]             out_type_q;

  assign res_data = {res_data2, res_data1, res_data0};

  // The extra pointer bit separates full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = q_mem_q[rd_ptr_q[AW-1:0]];
  assign push  = issue_valid & ~full & (issue_type != 2'b11);

  assign head_vld_vec = {1'b0, hold_vld};
  assign load = (~out_valid_q | out_ready) & ~empty & head_vld_vec[head];

  always_comb begin
    head_data = hold_data[0];
    case (head)
      2'd1:    head_data = hold_data[1];
      2'd2:    head_data = hold_data[2];
      default: head_data = hold_data[0];
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < NP; k++) begin : g_path
      assign push_cls[k] = push & (issue_type == 2'(k));
      assign drain[k]    = load & (head == 2'(k));
      fpu_rm_path #(.W(W), .CW(AW+1)) u_path (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_cls[k]),
        .res_valid_i (res_valid[k]),
        .res_data_i  (res_data[k]),
        .drain_i     (drain[k]),
        .res_ready_o (res_ready[k]),
        .hold_vld_o  (hold_vld[k]),
        .hold_data_o (hold_data[k]),
        .drop_o      (drop[k])
      );
    end
  endgenerate

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = load ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    out_valid_d = out_valid_q;
    if (load)           out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mem_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_type_q  <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      if (push) q_mem_q[wr_ptr_q[AW-1:0]] <= issue_type;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      if (load) begin
        out_data_q <= head_data;
        out_type_q <= head;
      end
      if (|drop) err_q <= 1'b1;
    end
  end

  assign issue_ready = ~full;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_type    = out_type_q;
  assign err         = err_q;
endmodule

// File: tb/tb_fpu_result_merge.sv
// Randomized and directed stimulus against a queue-based reference model; a
// separate monitor scores every output handshake against the expected stream.

module tb_fpu_result_merge;
  localparam int DEPTH = 4;
  localparam int W     = 37;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         issue_valid = 1'b0;
  logic [1:0]   issue_type = 2'b00;
  logic         issue_ready;
  logic [2:0]   res_valid = 3'b000;
  logic [W-1:0] res_data0 = '0, res_data1 = '0, res_data2 = '0;
  logic [2:0]   res_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_type;
  logic         out_ready = 1'b0;
  logic         err;

  always #5 clk = ~clk;

  fpu_result_merge #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_ready(issue_ready),
    .res_valid(res_valid), .res_data0(res_data0), .res_data1(res_data1), .res_data2(res_data2),
    .res_ready(res_ready),
    .out_valid(out_valid), .out_data(out_data), .out_type(out_type), .out_ready(out_ready),
    .err(err)
  );

  typedef struct { logic [1:0] t; logic [W-1:0] d; } exp_s;
  exp_s sb[$];
  int nvec = 0, nmiss = 0;

  // Reference model: dispatch order, per-path held result, outstanding counts.
  int           mq[$];
  bit           mheld [3];
  logic [W-1:0] mhd   [3];
  int           mcnt  [3];
  bit           mov, merr;
  logic [W-1:0] mod;
  logic [1:0]   mot;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mreset();
    mq.delete();
    sb.delete();
    for (int k = 0; k < 3; k++) begin
      mheld[k] = 0; mhd[k] = '0; mcnt[k] = 0;
    end
    mov = 0; merr = 0; mod = '0; mot = 2'b00;
  endtask

  task automatic cyc(input bit iv, input logic [1:0] it, input logic [2:0] rv,
                     input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input logic [W-1:0] d2, input bit ordy);
    bit           push, load;
    bit           cap [3];
    int           h;
    logic [W-1:0] rd [3];
    exp_s         e;
    issue_valid = iv; issue_type = it; res_valid = rv;
    res_data0 = d0; res_data1 = d1; res_data2 = d2; out_ready = ordy;
    @(negedge clk);
    chk("issue_ready", 64'(issue_ready), 64'(mq.size() < DEPTH));
    chk("res_ready", 64'(res_ready), 64'({!mheld[2], !mheld[1], !mheld[0]}));
    chk("out_valid", 64'(out_valid), 64'(mov));
    if (mov) begin
      chk("out_data", 64'(out_data), 64'(mod));
      chk("out_type", 64'(out_type), 64'(mot));
    end
    chk("err", 64'(err), 64'(merr));
    rd = '{d0, d1, d2};
    push = iv && (mq.size() < DEPTH) && (it != 2'b11);
    load = (!mov || ordy) && (mq.size() > 0) && mheld[mq[0]];
    for (int k = 0; k < 3; k++) cap[k] = rv[k] && !mheld[k];
    if (load) begin
      h = mq.pop_front();
      e.t = 2'(h); e.d = mhd[h];
      sb.push_back(e);
      mov = 1; mod = mhd[h]; mot = 2'(h); mheld[h] = 0;
    end else if (ordy) mov = 0;
    for (int k = 0; k < 3; k++) begin
      if (cap[k]) begin
        if (mcnt[k] == 0 && !(push && int'(it) == k)) merr = 1;
        else begin mheld[k] = 1; mhd[k] = rd[k]; mcnt[k]--; end
      end
    end
    if (push) begin mq.push_back(int'(it)); mcnt[it]++; end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 3'b000, '0, '0, '0, ordy);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Keep answering every outstanding dispatch until everything has drained.
  task automatic drain_all();
    int n = 0;
    logic [2:0] rv;
    while ((mq.size() > 0 || mov) && n < 200) begin
      rv = {mcnt[2] > 0, mcnt[1] > 0, mcnt[0] > 0};
      cyc(0, 2'b00, rv, rnd(), rnd(), rnd(), 1);
      n++;
    end
    if (n >= 200) begin
      nvec++; nmiss++;
      $display("FAIL drain_timeout: got %0d pending want 0", mq.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        nvec++; nmiss++;
        $display("FAIL sb_underflow: got output %0h want none", out_data);
      end else begin
        exp_s e;
        e = sb.pop_front();
        chk("sb_type", 64'(out_type), 64'(e.t));
        chk("sb_data", 64'(out_data), 64'(e.d));
      end
    end
  end

  initial begin
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_res_ready", 64'(res_ready), 64'h7);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    // Single normal-class result, two-edge latency.
    cyc(1, 2'b01, 3'b000, '0, '0, '0, 1);
    cyc(0, 2'b00, 3'b010, '0, 37'h0_0000_1234, '0, 1);
    cyc(0, 2'b00, 3'b000, '0, '0, '0, 1);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_data", 64'(out_data), 64'h1234);
    chk("t1_out_type", 64'(out_type), 64'd1);
    idle(2, 1);

    // Out-of-order returns must leave in dispatch order.
    cyc(1, 2'b00, 3'b000, '0, '0, '0, 1);
    cyc(1, 2'b10, 3'b000, '0, '0, '0, 1);
    cyc(1, 2'b01, 3'b000, '0, '0, '0, 1);
    cyc(0, 2'b00, 3'b010, '0, 37'h11, '0, 1);
    idle(2, 1);
    cyc(0, 2'b00, 3'b100, '0, '0, 37'h22, 1);
    cyc(0, 2'b00, 3'b001, 37'h33, '0, '0, 1);
    idle(5, 1);

    // Fill the order queue, attempt a fifth dispatch, then free one slot.
    for (int i = 0; i < 4; i++) cyc(1, 2'b01, 3'b000, '0, '0, '0, 1);
    cyc(1, 2'b01, 3'b000, '0, '0, '0, 1);
    cyc(0, 2'b00, 3'b010, '0, 37'h44, '0, 1);
    idle(2, 1);
    drain_all();

    // Stray mix result: dropped, err sticks, traffic continues.
    cyc(0, 2'b00, 3'b100, '0, '0, 37'h1BAD, 1);
    idle(1, 1);
    cyc(1, 2'b01, 3'b000, '0, '0, '0, 1);
    cyc(0, 2'b00, 3'b010, '0, 37'h55, '0, 1);
    idle(3, 1);

    // Back-pressure with two results ready, then release.
    cyc(1, 2'b00, 3'b000, '0, '0, '0, 0);
    cyc(1, 2'b01, 3'b000, '0, '0, '0, 0);
    cyc(0, 2'b00, 3'b011, 37'h66, 37'h77, '0, 0);
    idle(4, 0);
    idle(4, 1);

    // Reset mid-operation with three tags queued and one held result.
    cyc(1, 2'b00, 3'b000, '0, '0, '0, 0);
    cyc(1, 2'b01, 3'b000, '0, '0, '0, 0);
    cyc(1, 2'b10, 3'b000, '0, '0, '0, 0);
    cyc(0, 2'b00, 3'b010, '0, 37'h88, '0, 0);
    issue_valid = 0; res_valid = 3'b000; out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("mid_rst_res_ready", 64'(res_ready), 64'h7);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_type", 64'(out_type), 64'd0);
    mreset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rv;
      for (int k = 0; k < 3; k++) rv[k] = (mcnt[k] > 0) && ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), rv,
          rnd(), rnd(), rnd(), $urandom_range(0, 3) != 0);
    end
    drain_all();
    idle(2, 1);
    chk("sb_leftover", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end
endmodule
